// File: rtl/booth_seq_mult_if.sv
// Handshake and operand bundle for booth_seq_mult.
//   start        : request, honoured only in IDLE or DONE
//   abort        : cancels an operation in progress
//   multiplicand : operand M
//   multiplier   : operand Q
//   is_signed    : operand signedness (only with BOOTH_UNSIGNED_MODE_EN defined)
//   busy         : high while iterating
//   done         : one-cycle product-valid pulse
//   product      : registered 2*WIDTH result
// The master modport is the requester side; the slave modport is the multiplier.
interface booth_seq_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic                 abort;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
`ifdef BOOTH_UNSIGNED_MODE_EN
  logic                 is_signed;
`endif
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

`ifdef BOOTH_UNSIGNED_MODE_EN
  modport master (output start, abort, multiplicand, multiplier, is_signed,
                  input  busy, done, product);
  modport slave  (input  start, abort, multiplicand, multiplier, is_signed,
                  output busy, done, product);
`else
  modport master (output start, abort, multiplicand, multiplier,
                  input  busy, done, product);
  modport slave  (input  start, abort, multiplicand, multiplier,
                  output busy, done, product);
`endif
endinterface

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   clear : synchronous active-low reset
//   bus   : booth_seq_mult_if.slave (start/abort/operands in, busy/done/product out)
// Optional feature: define BOOTH_UNSIGNED_MODE_EN to add the is_signed input. With
// is_signed=0 the operands are zero-extended to WIDTH+1 bits and WIDTH+1 steps are run.
// Default build is signed-only with WIDTH steps.
module booth_seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           clear,
  booth_seq_mult_if.slave bus
);

`ifdef BOOTH_UNSIGNED_MODE_EN
  localparam int unsigned QW = WIDTH + 1;
`else
  localparam int unsigned QW = WIDTH;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [QW-1:0]        q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef BOOTH_UNSIGNED_MODE_EN
  logic                 uns_q, uns_d;
`endif

  logic [WIDTH:0]       a_sum;
  logic [WIDTH:0]       a_sh;
  logic [QW-1:0]        q_sh;
  logic [2*WIDTH-1:0]   prod_step;

  // One Booth step: add/subtract M, then arithmetic shift of {A,Q,q_m1}.
  always_comb begin
    a_sum = a_q;
    unique case ({q_q[0], qm1_q})
      2'b10:   a_sum = a_q - m_q;
      2'b01:   a_sum = a_q + m_q;
      default: a_sum = a_q;
    endcase
    a_sh = {a_sum[WIDTH], a_sum[WIDTH:1]};
`ifdef BOOTH_UNSIGNED_MODE_EN
    if (uns_q) begin
      q_sh      = {a_sum[0], q_q[QW-1:1]};
      prod_step = {a_sh[WIDTH-2:0], q_sh};
    end else begin
      // Signed operands only use the low WIDTH bits of Q; the top bit stays zero.
      q_sh      = {1'b0, a_sum[0], q_q[WIDTH-1:1]};
      prod_step = {a_sh[WIDTH-1:0], q_sh[WIDTH-1:0]};
    end
`else
    q_sh      = {a_sum[0], q_q[WIDTH-1:1]};
    prod_step = {a_sh[WIDTH-1:0], q_sh};
`endif
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef BOOTH_UNSIGNED_MODE_EN
    uns_d     = uns_q;
`endif

    unique case (state_q)
      StIter: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          a_d   = a_sh;
          q_d   = q_sh;
          qm1_d = q_q[0];
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d   = StDone;
            product_d = prod_step;
          end
        end
      end
      StDone:  state_d = bus.start ? StIter : StIdle;
      default: state_d = bus.start ? StIter : StIdle;
    endcase

    // Accept a new operation; start wins over abort outside ITER.
    if (state_q != StIter && bus.start) begin
      a_d   = '0;
      qm1_d = 1'b0;
      q_d   = QW'(bus.multiplier);
`ifdef BOOTH_UNSIGNED_MODE_EN
      uns_d = ~bus.is_signed;
      if (bus.is_signed) begin
        m_d   = {bus.multiplicand[WIDTH-1], bus.multiplicand};
        cnt_d = CW'(WIDTH);
      end else begin
        m_d   = {1'b0, bus.multiplicand};
        cnt_d = CW'(WIDTH + 1);
      end
`else
      m_d   = {bus.multiplicand[WIDTH-1], bus.multiplicand};
      cnt_d = CW'(WIDTH);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q   <= StIdle;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef BOOTH_UNSIGNED_MODE_EN
      uns_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef BOOTH_UNSIGNED_MODE_EN
      uns_q     <= uns_d;
`endif
    end
  end

  assign bus.busy    = (state_q == StIter);
  assign bus.done    = (state_q == StDone);
  assign bus.product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed self-checking bench for booth_seq_mult at WIDTH=8.
module tb_booth_seq_mult;
  localparam int unsigned W = 8;

  logic clk;
  logic clear;
  int   n_chk = 0;
  int   n_bad = 0;

  booth_seq_mult_if #(.WIDTH(W)) bus_if ();

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge, then scramble the operand inputs.
  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic sgn);
    bus_if.start        = 1'b1;
    bus_if.multiplicand = m;
    bus_if.multiplier   = q;
`ifdef BOOTH_UNSIGNED_MODE_EN
    bus_if.is_signed    = sgn;
`else
    if (sgn) begin end
`endif
    tick();
    bus_if.start        = 1'b0;
    bus_if.multiplicand = W'($urandom);
    bus_if.multiplier   = W'($urandom);
  endtask

  // Count busy cycles (pre already spent), then check latency, done and product.
  task automatic wait_done(input string tag, input int pre, input int n_exp,
                           input logic [2*W-1:0] exp);
    int cnt;
    cnt = pre;
    while (bus_if.busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    check({tag, "_lat"}, 32'(cnt), 32'(n_exp));
    check({tag, "_done"}, 32'(bus_if.done), 32'd1);
    check({tag, "_prod"}, 32'(bus_if.product), 32'(exp));
  endtask

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[4] = '{
    '{m: 8'h7F, q: 8'h7F, p: 16'h3F01},
    '{m: 8'h00, q: 8'h55, p: 16'h0000},
    '{m: 8'hFF, q: 8'h01, p: 16'hFFFF},
    '{m: 8'hF6, q: 8'hF6, p: 16'h0064}
  };

  initial begin
    bus_if.start        = 1'b0;
    bus_if.abort        = 1'b0;
    bus_if.multiplicand = '0;
    bus_if.multiplier   = '0;
`ifdef BOOTH_UNSIGNED_MODE_EN
    bus_if.is_signed    = 1'b1;
`endif
    clear = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_prod", 32'(bus_if.product), 32'd0);
    clear = 1'b1;
    tick();

    // 3 * -5
    start_op(8'h03, 8'hFB, 1'b1);
    wait_done("m3q-5", 0, 8, 16'hFFF1);
    tick();
    check("done_pulse", 32'(bus_if.done), 32'd0);

    // Back-to-back: second start issued in the DONE cycle.
    start_op(8'h80, 8'h80, 1'b1);
    wait_done("min_min", 0, 8, 16'h4000);
    start_op(8'h7F, 8'h80, 1'b1);
    wait_done("b2b", 0, 8, 16'hC080);
    tick();

    foreach (vecs[i]) begin
      start_op(vecs[i].m, vecs[i].q, 1'b1);
      wait_done($sformatf("vec%0d", i), 0, 8, vecs[i].p);
      tick();
    end

    // Start pulsed mid-ITER must be ignored.
    start_op(8'h03, 8'hFB, 1'b1);
    tick();
    tick();
    bus_if.start        = 1'b1;
    bus_if.multiplicand = 8'h11;
    bus_if.multiplier   = 8'h22;
    tick();
    bus_if.start        = 1'b0;
    wait_done("ign_start", 3, 8, 16'hFFF1);
    tick();

    // Abort in ITER cycle 4.
    start_op(8'h11, 8'h22, 1'b1);
    tick();
    tick();
    tick();
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    check("abort_busy", 32'(bus_if.busy), 32'd0);
    check("abort_done", 32'(bus_if.done), 32'd0);
    check("abort_prod", 32'(bus_if.product), 32'hFFF1);
    tick();
    check("abort_done2", 32'(bus_if.done), 32'd0);

    // Clear mid-ITER discards everything.
    start_op(8'h7F, 8'h7F, 1'b1);
    tick();
    clear = 1'b0;
    tick();
    clear = 1'b1;
    check("clr_busy", 32'(bus_if.busy), 32'd0);
    check("clr_done", 32'(bus_if.done), 32'd0);
    check("clr_prod", 32'(bus_if.product), 32'd0);
    tick();
    check("clr_done2", 32'(bus_if.done), 32'd0);

    // start and abort together in IDLE: start wins.
    bus_if.abort = 1'b1;
    start_op(8'h05, 8'h06, 1'b1);
    bus_if.abort = 1'b0;
    check("st_ab_busy", 32'(bus_if.busy), 32'd1);
    wait_done("st_ab", 0, 8, 16'h001E);
    tick();

`ifdef BOOTH_UNSIGNED_MODE_EN
    start_op(8'hFF, 8'hFF, 1'b0);
    wait_done("uns_ff", 0, 9, 16'hFE01);
    tick();
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done("sgn_ff", 0, 8, 16'h0001);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 clear  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 start  input  1  request; sampled only when the FSM is in IDLE or DONE.
REQ-005 abort  input  1  cancels an operation in progress; ignored outside ITER.
REQ-006 multiplicand  input  WIDTH  operand M; two's complement, or per REQ-024.
REQ-007 multiplier  input  WIDTH  operand Q; two's complement, or per REQ-024.
REQ-008 busy  output  1  high while in ITER.
REQ-009 done  output  1  one-cycle pulse; product valid.
REQ-010 product  output  2*WIDTH  registered result; held until the next completion.

Function
REQ-011 FSM states IDLE, ITER, DONE; encoding is free.
- IDLE: start=1 -> ITER; else stay.
- ITER: abort=1 -> IDLE; count reaches 0 -> DONE; else stay.
- DONE: start=1 -> ITER; else IDLE.
REQ-012 On start acceptance: operands sampled into M and Q; A (WIDTH+1 bits) and q_m1 cleared; count loaded with N; N=WIDTH in signed mode.
REQ-013 Each ITER cycle performs one radix-2 Booth step:
- {Q[0],q_m1}=10 -> A-sext(M); =01 -> A+sext(M); 00/11 -> A unchanged.
- Arithmetic right shift of {A,Q,q_m1} by one.
- count decremented by 1.
REQ-014 A is WIDTH+1 bits wide, so M = -2^(WIDTH-1) is handled without overflow.
REQ-015 On the ITER->DONE transition, product is loaded with the low 2*WIDTH bits of {A,Q}.
REQ-016 Latency:
- start sampled at edge k -> done high in the cycle following edge k+N.
- busy high for exactly N cycles.
- done high for exactly 1 cycle.
REQ-017 start is ignored while busy=1; operands, count and FSM are unaffected.
REQ-018 start during DONE is accepted; back-to-back throughput is N+1 cycles per product.
REQ-019 abort in ITER returns the FSM to IDLE at the next edge, with no done and product unchanged; when start and abort are both high in IDLE or DONE, start is accepted.
REQ-020 Operand inputs may change freely after acceptance without affecting the result.

Reset
REQ-021 clear=0 at a rising edge forces:
- FSM to IDLE; busy=0, done=0, product=0.
- A, Q, M, q_m1, count all 0.
REQ-022 clear has priority over start and abort; reset mid-ITER discards the operation with no done.
REQ-023 Outputs are driven from registers or state decode only; nothing is undefined after the first reset edge.

Configuration
REQ-024 Macro BOOTH_UNSIGNED_MODE_EN:
- Defined: adds input port is_signed (1 bit), sampled at start acceptance.
  - is_signed=1: signed operation as above.
  - is_signed=0: operands zero-extended to WIDTH+1 bits; N=WIDTH+1; result is the unsigned product.
- Undefined: no is_signed port; operation is always signed with N=WIDTH.

Verification (WIDTH=8)
REQ-025 clear low for 2 cycles, then high; start=1, M=3, Q=-5 (8'hFB) -> busy high for 8 cycles; done pulses 9 cycles after start; product=16'hFFF1.
REQ-026 M=8'h80, Q=8'h80 -> product=16'h4000; then M=8'h7F, Q=8'h80 -> product=16'hC080, issued back-to-back by asserting start in the DONE cycle.
REQ-027 During ITER, pulse start with different operands -> ignored; original product is delivered at the original latency.
REQ-028 abort at ITER cycle 4 -> busy drops next cycle, no done, product keeps its previous value; clear=0 mid-ITER -> all outputs 0 next cycle.
REQ-029 With BOOTH_UNSIGNED_MODE_EN defined: is_signed=0, M=8'hFF, Q=8'hFF -> done after 10 cycles, product=16'hFE01; is_signed=1 with the same operands -> product=16'h0001.
